// File: rtl/npu_mem_pkg.sv
// Shared types and constants for the NPU activation/weight buffer scheduler.
package npu_mem_pkg;

  // Which requester was granted the RAM port most recently.
  typedef enum logic {S_LAST_WR, S_LAST_RD} arb_state_t;

  localparam int NPU_WORD_W        = 32;
  localparam int NPU_LANE_W        = 8;
  localparam int NPU_LANES         = NPU_WORD_W / NPU_LANE_W;
  localparam int NPU_DEFAULT_DEPTH = 16;

endpackage

// File: rtl/npu_sp_ram.sv
// Single-port RAM with a registered read port; contents are not reset.
module npu_sp_ram
  import npu_mem_pkg::*;
#(
  parameter int DEPTH = NPU_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [NPU_WORD_W-1:0] wdata,
  output logic [NPU_WORD_W-1:0] rdata
);

  logic [NPU_WORD_W-1:0] r_mem [DEPTH];

  // Write when enabled; the read register samples the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/npu_mem_sched.sv
// Round-robin scheduler sharing one single-port RAM between the host write
// port and the NPU read stream, with the RAM run as a circular buffer.
module npu_mem_sched
  import npu_mem_pkg::*;
#(
  parameter int DEPTH = NPU_DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NPU_WORD_W-1:0]       writedata,
  input  logic                        write,
  input  logic                        chipselect,
  input  logic                        reading,
  output logic                        waitrequest,
  output logic [NPU_LANE_W-1:0]       data0,
  output logic [NPU_LANE_W-1:0]       data1,
  output logic [NPU_LANE_W-1:0]       data2,
  output logic [NPU_LANE_W-1:0]       data3,
  output logic                        data_valid,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int AW = $clog2(DEPTH);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_rd_pend;
  logic [NPU_WORD_W-1:0] r_lane_hold;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic [AW-1:0]         w_addr;
  logic [NPU_WORD_W-1:0] w_rdata;
  logic                  w_rd_valid;
  logic [NPU_WORD_W-1:0] w_word;
  logic [NPU_LANE_W-1:0] w_lane [NPU_LANES];

  assign full     = (r_count == (AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign w_wr_req = chipselect & write & ~full;
  assign w_rd_req = reading & ~empty;

  // Arbiter next state: a lone requester wins, a tie goes to the side not served last.
  always_comb begin
    w_wr_gnt     = 1'b0;
    w_rd_gnt     = 1'b0;
    w_state_next = r_state;
    if (w_wr_req && w_rd_req) begin
      if (r_state == S_LAST_RD) begin
        w_wr_gnt     = 1'b1;
        w_state_next = S_LAST_WR;
      end else begin
        w_rd_gnt     = 1'b1;
        w_state_next = S_LAST_RD;
      end
    end else if (w_wr_req) begin
      w_wr_gnt     = 1'b1;
      w_state_next = S_LAST_WR;
    end else if (w_rd_req) begin
      w_rd_gnt     = 1'b1;
      w_state_next = S_LAST_RD;
    end
  end

  // Arbiter state register; reset favours the writer on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LAST_RD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Circular-buffer pointers and occupancy; at most one grant per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_wr_gnt) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count  <= r_count + (AW+1)'(1);
    end else if (w_rd_gnt) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count - (AW+1)'(1);
    end
  end

  assign w_addr      = w_wr_gnt ? r_wr_ptr : r_rd_ptr;
  assign waitrequest = chipselect & write & ~w_wr_gnt;

  npu_sp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_gnt),
    .addr  (w_addr),
    .wdata (writedata),
    .rdata (w_rdata)
  );

  // Track an outstanding read and keep the last popped word for the hold phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend   <= 1'b0;
      r_lane_hold <= '0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (r_rd_pend) begin
        r_lane_hold <= w_rdata;
      end
    end
  end

  // The RAM read register already carries the word in the cycle after the
  // grant; a reset in that cycle suppresses the pulse so it is discarded.
  assign w_rd_valid = r_rd_pend & ~reset;
  assign w_word     = w_rd_valid ? w_rdata : r_lane_hold;
  assign data_valid = w_rd_valid;

  for (genvar gi = 0; gi < NPU_LANES; gi++) begin : g_lane
    assign w_lane[gi] = w_word[gi*NPU_LANE_W +: NPU_LANE_W];
  end

  assign data0 = w_lane[0];
  assign data1 = w_lane[1];
  assign data2 = w_lane[2];
  assign data3 = w_lane[3];

endmodule

// File: tb/tb_npu_mem_sched.sv
// Directed bench for npu_mem_sched (DEPTH = 16).
module tb_npu_mem_sched;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic        write;
  logic        chipselect;
  logic        reading;
  logic        waitrequest;
  logic [7:0]  data0, data1, data2, data3;
  logic        data_valid;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic [31:0] w_word;

  int n_chk;
  int n_fail;

  npu_mem_sched #(.DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .writedata   (writedata),
    .write       (write),
    .chipselect  (chipselect),
    .reading     (reading),
    .waitrequest (waitrequest),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .data3       (data3),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .count       (count)
  );

  assign w_word = {data3, data2, data1, data0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; reading = 1'b0; writedata = '0;
    step(); step();
    reset = 1'b0;
  endtask

  // Write n consecutive words base, base+1, ...; each must be granted at once.
  task automatic write_words(input int n, input logic [31:0] base);
    chipselect = 1'b1; write = 1'b1;
    for (int i = 0; i < n; i++) begin
      writedata = base + 32'(i);
      #1;
      chk("wr_nowait", 32'(waitrequest), 0);
      step();
    end
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Hold reading high and expect words base.. base+n-1 in order, one per cycle.
  task automatic drain_check(input int n, input logic [31:0] base);
    reading = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("drain_dv", 32'(data_valid), 1);
      chk("drain_word", w_word, base + 32'(i));
    end
    reading = 1'b0;
    step();
    chk("drain_dv_end", 32'(data_valid), 0);
    chk("drain_empty", 32'(empty), 1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;

    // Reset state
    do_reset();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_word", w_word, 0);
    chk("rst_wait", 32'(waitrequest), 0);

    // Single write, then read: data_valid two cycles after the write grant
    chipselect = 1'b1; write = 1'b1; writedata = 32'h0F00_0133;
    #1;
    chk("t1_wait", 32'(waitrequest), 0);
    step();
    chipselect = 1'b0; write = 1'b0; reading = 1'b1;
    #1;
    chk("t1_count1", 32'(count), 1);
    chk("t1_dv_early", 32'(data_valid), 0);
    step();
    reading = 1'b0;
    #1;
    chk("t1_dv", 32'(data_valid), 1);
    chk("t1_d0", 32'(data0), 32'h33);
    chk("t1_d1", 32'(data1), 32'h01);
    chk("t1_d2", 32'(data2), 32'h00);
    chk("t1_d3", 32'(data3), 32'h0F);
    chk("t1_count0", 32'(count), 0);
    chk("t1_empty", 32'(empty), 1);
    step();
    chk("t1_dv_low", 32'(data_valid), 0);
    chk("t1_hold", w_word, 32'h0F00_0133);

    // Fill to full, stall a write, free one slot, pending write completes
    do_reset();
    write_words(16, 32'h1111_0000);
    chipselect = 1'b1; write = 1'b1; writedata = 32'h1111_0010;
    #1;
    chk("t2_full", 32'(full), 1);
    chk("t2_count16", 32'(count), 16);
    chk("t2_wait_full", 32'(waitrequest), 1);
    step();
    chk("t2_wait_hold", 32'(waitrequest), 1);
    chk("t2_count_hold", 32'(count), 16);
    reading = 1'b1;
    #1;
    chk("t2_wait_rdgnt", 32'(waitrequest), 1);
    step();
    reading = 1'b0;
    #1;
    chk("t2_wait_free", 32'(waitrequest), 0);
    chk("t2_count15", 32'(count), 15);
    chk("t2_dv", 32'(data_valid), 1);
    chk("t2_word0", w_word, 32'h1111_0000);
    step();
    chipselect = 1'b0; write = 1'b0;
    #1;
    chk("t2_refull", 32'(count), 16);
    drain_check(16, 32'h1111_0001);

    // Wrap-around: fill, drain, 4 more, drain
    do_reset();
    write_words(16, 32'h3000_0000);
    drain_check(16, 32'h3000_0000);
    write_words(4, 32'h3000_0010);
    drain_check(4, 32'h3000_0010);
    chk("t3_wr_ptr", 32'(dut.r_wr_ptr), 4);
    chk("t3_rd_ptr", 32'(dut.r_rd_ptr), 4);
    chk("t3_count", 32'(count), 0);

    // Contention: preload 9, pop one (arbiter last = read), then 8 tie cycles
    do_reset();
    write_words(9, 32'h4000_0000);
    reading = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      chipselect = 1'b1; write = 1'b1; reading = 1'b1;
      writedata = 32'h4000_0100 + 32'(k / 2);
      #1;
      chk("t4_wait", 32'(waitrequest), ((k % 2) == 1) ? 32'd1 : 32'd0);
      chk("t4_dv", 32'(data_valid), ((k % 2) == 0) ? 32'd1 : 32'd0);
      if ((k % 2) == 0) begin
        chk("t4_word", w_word, 32'h4000_0000 + 32'(k / 2));
      end
      step();
    end
    chipselect = 1'b0; write = 1'b0; reading = 1'b0;
    #1;
    chk("t4_dv_last", 32'(data_valid), 1);
    chk("t4_word_last", w_word, 32'h4000_0004);
    chk("t4_count", 32'(count), 8);

    // Read on empty: nothing happens
    do_reset();
    reading = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_dv", 32'(data_valid), 0);
      chk("t5_count", 32'(count), 0);
      chk("t5_rd_ptr", 32'(dut.r_rd_ptr), 0);
    end
    reading = 1'b0;

    // Reset in the cycle after a read grant discards the read
    do_reset();
    write_words(1, 32'hA1B2_C3D4);
    reading = 1'b1;
    step();
    reading = 1'b0;
    chk("t6_dv_a", 32'(data_valid), 1);
    chk("t6_word_a", w_word, 32'hA1B2_C3D4);
    write_words(1, 32'h5566_7788);
    reading = 1'b1;
    step();
    reading = 1'b0; reset = 1'b1;
    #1;
    chk("t6_dv_in_rst", 32'(data_valid), 0);
    step();
    reset = 1'b0;
    #1;
    chk("t6_dv_after", 32'(data_valid), 0);
    chk("t6_word", w_word, 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    step();
    chk("t6_dv_next", 32'(data_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
